// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I constants and control-transfer types
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        XFER_NONE   = 2'd0,
        XFER_BRANCH = 2'd1,
        XFER_JAL    = 2'd2,
        XFER_JALR   = 2'd3
    } xfer_e;

    // JALR outranks JAL, which outranks a conditional branch
    function automatic xfer_e xfer_decode(input logic branch, input logic jump, input logic jalr);
        if (jalr)
            return XFER_JALR;
        else if (jump)
            return XFER_JAL;
        else if (branch)
            return XFER_BRANCH;
        else
            return XFER_NONE;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - execute-stage control-transfer bus between pipeline and resolver
interface branch_resolve_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             ValidE;
    logic             BranchE;
    logic             JumpE;
    logic             JalrE;
    logic [2:0]       funct3E;
    logic [XLEN-1:0]  SrcAE;
    logic [XLEN-1:0]  SrcBE;
    logic [XLEN-1:0]  PCE;
    logic [XLEN-1:0]  ImmExtE;
    logic             perf_clr;

    logic             PCSrcE;
    logic [XLEN-1:0]  JumpTarget_E;
    logic             FlushD;
    logic             FlushE;
    logic             MisalignE;
    logic             misalign_sticky;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] jump_cnt;

    modport master (
        output ValidE, BranchE, JumpE, JalrE, funct3E, SrcAE, SrcBE, PCE, ImmExtE, perf_clr,
        input  PCSrcE, JumpTarget_E, FlushD, FlushE, MisalignE, misalign_sticky,
        input  br_cnt, taken_cnt, jump_cnt
    );

    modport slave (
        input  ValidE, BranchE, JumpE, JalrE, funct3E, SrcAE, SrcBE, PCE, ImmExtE, perf_clr,
        output PCSrcE, JumpTarget_E, FlushD, FlushE, MisalignE, misalign_sticky,
        output br_cnt, taken_cnt, jump_cnt
    );
endinterface

// File: rtl/branch_cmp.sv
// rtl/branch_cmp.sv - funct3-selected branch condition comparator
module branch_cmp
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_cond
);
    logic w_eq;
    logic w_lt;
    logic w_ltu;

    assign w_eq  = (i_a == i_b);
    assign w_lt  = ($signed(i_a) < $signed(i_b));
    assign w_ltu = (i_a < i_b);

    // 010/011 are reserved encodings and never resolve taken
    always_comb begin
        o_cond = 1'b0;
        case (i_funct3)
            F3_BEQ:  o_cond = w_eq;
            F3_BNE:  o_cond = ~w_eq;
            F3_BLT:  o_cond = w_lt;
            F3_BGE:  o_cond = ~w_lt;
            F3_BLTU: o_cond = w_ltu;
            F3_BGEU: o_cond = ~w_ltu;
            default: o_cond = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - execute-stage branch/jump resolver driving the PC redirect and flushes
module branch_resolve_unit
    import riscv_pkg::*;
#(
    parameter int XLEN    = riscv_pkg::XLEN,
    parameter int CNT_W   = 32,
    parameter bit PERF_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_resolve_unit_if.slave  bus
);
    xfer_e            w_kind;
    logic             w_eff_v;
    logic             w_cond;
    logic [XLEN-1:0]  w_pc_sum;
    logic [XLEN-1:0]  w_jalr_sum;
    logic [XLEN-1:0]  w_target;
    logic             w_take;
    logic             w_misalign;
    logic             w_redirect;
    logic             w_br_inc;
    logic             w_taken_inc;
    logic             w_jump_inc;

    logic             r_shadow_q;
    logic             r_misalign_sticky;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_taken_cnt;
    logic [CNT_W-1:0] r_jump_cnt;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .i_funct3 (bus.funct3E),
        .i_a      (bus.SrcAE),
        .i_b      (bus.SrcBE),
        .o_cond   (w_cond)
    );

    // The slot right after a redirect holds a wrong-path instruction; treat it as a bubble
    assign w_eff_v    = bus.ValidE & ~r_shadow_q & ~rst;
    assign w_kind     = xfer_decode(bus.BranchE, bus.JumpE, bus.JalrE);

    assign w_pc_sum   = bus.PCE + bus.ImmExtE;
    assign w_jalr_sum = bus.SrcAE + bus.ImmExtE;

    always_comb begin
        w_target = w_pc_sum;
        if (w_kind == XFER_JALR)
            w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
    end

    assign w_take     = w_eff_v & (bus.JumpE | bus.JalrE | (bus.BranchE & w_cond));
    assign w_misalign = w_take & w_target[1];
    assign w_redirect = w_take & ~w_misalign;

    assign bus.PCSrcE       = w_redirect;
    assign bus.JumpTarget_E = rst ? '0 : w_target;
    assign bus.FlushD       = w_redirect;
    assign bus.FlushE       = w_redirect;
    assign bus.MisalignE    = w_misalign;

    always_ff @(posedge clk) begin
        if (rst)
            r_shadow_q <= 1'b0;
        else
            r_shadow_q <= w_redirect;
    end

    always_ff @(posedge clk) begin
        if (rst || bus.perf_clr)
            r_misalign_sticky <= 1'b0;
        else if (w_misalign)
            r_misalign_sticky <= 1'b1;
    end

    assign bus.misalign_sticky = r_misalign_sticky;

    assign w_br_inc    = w_eff_v & bus.BranchE & ~bus.JumpE & ~bus.JalrE;
    assign w_taken_inc = w_br_inc & w_cond & ~w_misalign;
    assign w_jump_inc  = w_eff_v & (bus.JumpE | bus.JalrE) & ~w_misalign;

    generate
        if (PERF_EN) begin : g_perf
            always_ff @(posedge clk) begin
                if (rst || bus.perf_clr) begin
                    r_br_cnt    <= '0;
                    r_taken_cnt <= '0;
                    r_jump_cnt  <= '0;
                end else begin
                    r_br_cnt    <= r_br_cnt    + CNT_W'(w_br_inc);
                    r_taken_cnt <= r_taken_cnt + CNT_W'(w_taken_inc);
                    r_jump_cnt  <= r_jump_cnt  + CNT_W'(w_jump_inc);
                end
            end
        end else begin : g_noperf
            always_ff @(posedge clk) begin
                r_br_cnt    <= '0;
                r_taken_cnt <= '0;
                r_jump_cnt  <= '0;
            end
        end
    endgenerate

    assign bus.br_cnt    = r_br_cnt;
    assign bus.taken_cnt = r_taken_cnt;
    assign bus.jump_cnt  = r_jump_cnt;
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage control-transfer resolver for the 5-stage RV32I pipeline; the producer of the PC redirect that the fetch-stage next-PC select consumes.
- Evaluates branch conditions and computes branch, JAL and JALR targets, then drives PCSrcE and JumpTarget_E.
- Generates the flushes for the wrong-path instructions in D and E.
- Holds a redirect-shadow guard, a sticky misaligned-target flag and wrap-around performance counters.

Parameters:
- XLEN, 32, datapath and address width.
- CNT_W, 32, width of each performance counter.
- PERF_EN, 1, 1 instantiates the counters; 0 ties the counter outputs to 0.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- ValidE  in  1  a real (non-bubble) instruction occupies E.
- BranchE  in  1  conditional branch in E.
- JumpE  in  1  JAL in E.
- JalrE  in  1  JALR in E.
- funct3E  in  3  branch condition code.
- SrcAE  in  XLEN  forwarded rs1 value.
- SrcBE  in  XLEN  forwarded rs2 value.
- PCE  in  XLEN  PC of the instruction in E.
- ImmExtE  in  XLEN  sign-extended immediate.
- perf_clr  in  1  synchronous clear of counters and sticky flag.
- PCSrcE  out  1  redirect select (1 = take JumpTarget_E).
- JumpTarget_E  out  XLEN  redirect address.
- FlushD  out  1  squash the IF/ID register.
- FlushE  out  1  squash the ID/EX register.
- MisalignE  out  1  single-cycle pulse: a taken target is misaligned.
- misalign_sticky  out  1  latched misalign indication.
- br_cnt  out  CNT_W  resolved conditional branches.
- taken_cnt  out  CNT_W  taken conditional branches.
- jump_cnt  out  CNT_W  executed JAL/JALR.

Behaviour:
- Priority of the instruction-type inputs: JalrE > JumpE > BranchE.
- Effective valid: effV = ValidE & ~shadow_q & ~rst.
- Condition, by funct3E:
  - 000 EQ, 001 NE.
  - 100 LT signed, 101 GE signed.
  - 110 LTU, 111 GEU.
  - 010/011 are never taken.
- Targets:
  - JALR: (SrcAE + ImmExtE) with bit 0 cleared.
  - Otherwise: PCE + ImmExtE.
  - Both additions are modulo 2^XLEN, so wrap-around is legal.
- take = effV & (JumpE | JalrE | (BranchE & cond)).
- misalign = take & (target[1] == 1). No compressed-instruction support exists.
- Outputs, all combinational in the same cycle (zero latency, so the next-PC select updates the PC on the next edge):
  - PCSrcE = take & ~misalign.
  - JumpTarget_E = target, driven even when PCSrcE = 0.
  - FlushD = FlushE = PCSrcE.
  - MisalignE = misalign.
- shadow_q register:
  - Next value is PCSrcE.
  - While shadow_q is 1 the instruction in E is treated as a bubble: no redirect, no counting. This guards against a flushed slot redirecting again.
- misalign_sticky: set when misalign = 1; cleared only by rst or perf_clr. If both occur in the same cycle, the clear wins.
- Counters, updated only on effV:
  - br_cnt += BranchE & ~JumpE & ~JalrE.
  - taken_cnt += that term & cond & ~misalign.
  - jump_cnt += (JumpE | JalrE) & ~misalign.
  - Each counter wraps from all-ones to 0.
  - perf_clr has priority over an increment in the same cycle.
- Reset (rst = 1):
  - All combinational outputs are forced to 0 in that cycle.
  - shadow_q, misalign_sticky and all counters = 0 after the edge.
  - A mid-operation reset aborts any redirect in flight; the cycle after reset is never a shadow cycle.
- Back-to-back taken branches: the second one is in the shadow and is ignored. This is correct, because that slot is the wrong path.
- Multiple type inputs asserted together: the priority order above decides the target. Each counter is incremented at most once per cycle.

Decomposition:
- Shared package riscv_pkg holds:
  - F3_BEQ / F3_BNE / F3_BLT / F3_BGE / F3_BLTU / F3_BGEU constants.
  - XLEN default.
- One natural sub-module, branch_cmp: a purely combinational funct3-driven comparator producing cond.
- Counters, the shadow register and target logic stay in the top module.

Test Plan:
1. BEQ with SrcAE = SrcBE = 0x5, PCE = 0x100, Imm = 0x20:
   - Same cycle: PCSrcE = 1, JumpTarget_E = 0x120, FlushD = FlushE = 1.
   - Next cycle, with ValidE = 1 and a taken branch presented: PCSrcE = 0 (shadow).
2. BLT with SrcAE = 0xFFFFFFFF, SrcBE = 0x1: taken. BLTU with the same operands: not taken.
   - Expected after both: br_cnt = 2, taken_cnt = 1.
3. JALR with SrcAE = 0x203, Imm = 0x0: target 0x202 has bit1 = 1.
   - Expected: PCSrcE = 0, MisalignE = 1, misalign_sticky = 1 until perf_clr.
   - jump_cnt is unchanged.
4. JAL with PCE = 0xFFFFFFF0, Imm = 0x20: JumpTarget_E = 0x00000010 (wrap), PCSrcE = 1.
5. Preload jump_cnt = 0xFFFFFFFF (CNT_W = 32) and issue a JAL: counter wraps to 0.
   - perf_clr asserted in the same cycle as a JAL: counter = 0 afterward.
6. Assert rst in the cycle a taken BNE is presented:
   - PCSrcE = 0.
   - After the edge: all counters, shadow_q and misalign_sticky = 0.
   - The next valid taken branch redirects immediately.
